cookie_serial_display: RTL and testbench

//  Downstream stage of the cookie core. Deserialises output_bit, qualified by the display_shift_out strobe, into frames.

---
 rtl/cookie_disp_pkg.sv | 20 ++
 rtl/hex_to_7seg.sv | 12 +
 rtl/cookie_serial_display.sv | 156 +++++++++++++++
 tb/tb_cookie_serial_display.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cookie_disp_pkg.sv
// cookie_disp_pkg: shared types and glyph table for the cookie display stage.
// Holds the receive FSM state enum, the hex segment table and the blank glyph.
package cookie_disp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high, index = hex value.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational nibble to 7-segment glyph lookup.
// Ports: nib (4-bit hex value in), seg (7-bit {g,f,e,d,c,b,a} out).
module hex_to_7seg
  import cookie_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[nib];

endmodule

// File: rtl/cookie_serial_display.sv
// cookie_serial_display: deserialises strobed bits into frames and scans
// each latched frame in hex onto a multiplexed common-cathode 7-seg display.
// Ports: clk, rst (sync, active-high), en (freeze when 0), bit_in/bit_valid
// (serial in), frame_word/frame_done/frame_error/bit_count (frame status),
// seg/digit_sel (registered display drive).
// Build option: COOKIE_DISP_TIMEOUT_EN adds a partial-frame idle timeout.
module cookie_serial_display
  import cookie_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1024,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  output logic [4*NUM_DIGITS-1:0]       frame_word,
  output logic                          frame_done,
  output logic                          frame_error,
  output logic [$clog2(4*NUM_DIGITS):0] bit_count,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         digit_sel
);

  localparam int FB = 4 * NUM_DIGITS;
  localparam int CW = $clog2(FB) + 1;
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

  if (REFRESH_DIV < 2 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("REFRESH_DIV and TIMEOUT_CYCLES must be >= 2");
  end

  state_t          state, state_nxt;
  logic [FB-1:0]   shreg, sh_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic            done_nxt, err_nxt, word_ld;
  logic            accept, last, mid, tmo;

  logic [PW-1:0]   prescaler, pre_nxt;
  logic [DW-1:0]   idx, idx_nxt;
  logic            wrap;
  logic [3:0]      nib;
  logic [6:0]      seg_nxt;

  assign accept = en && bit_valid;
  assign last   = accept && (bit_count == CW'(FB - 1));
  assign mid    = accept && !last;

`ifdef COOKIE_DISP_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  logic [IW-1:0] idle_cnt;

  // Fires on the idle edge that would bring the count to TIMEOUT_CYCLES-1.
  assign tmo = en && !accept && (state == RECV)
            && (idle_cnt == IW'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (rst)
      idle_cnt <= '0;
    else if (en) begin
      if (accept || tmo || state != RECV)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    sh_nxt    = shreg;
    cnt_nxt   = bit_count;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    word_ld   = 1'b0;
    unique case (1'b1)
      last: begin
        sh_nxt    = {shreg[FB-2:0], bit_in};
        cnt_nxt   = '0;
        state_nxt = IDLE;
        word_ld   = 1'b1;
        done_nxt  = 1'b1;
      end
      mid: begin
        sh_nxt    = {shreg[FB-2:0], bit_in};
        cnt_nxt   = bit_count + 1'b1;
        state_nxt = RECV;
      end
      tmo: begin
        sh_nxt    = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
        err_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  assign wrap    = prescaler == PW'(REFRESH_DIV - 1);
  assign pre_nxt = wrap ? '0 : prescaler + 1'b1;

  always_comb begin
    idx_nxt = idx;
    if (wrap)
      idx_nxt = (idx == DW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
  end

  // Glyph comes from the digit about to be active, so seg and
  // digit_sel switch together on the same edge.
  always_comb begin
    nib = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (idx_nxt == DW'(k))
        nib = frame_word[4*k +: 4];
  end

  hex_to_7seg u_hex (
    .nib (nib),
    .seg (seg_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_count   <= '0;
      frame_word  <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      prescaler   <= '0;
      idx         <= '0;
      digit_sel   <= NUM_DIGITS'(1);
      seg         <= HEX_GLYPH[0];
    end else begin
      state       <= state_nxt;
      shreg       <= sh_nxt;
      bit_count   <= cnt_nxt;
      frame_done  <= done_nxt;
      frame_error <= err_nxt;
      if (word_ld)
        frame_word <= sh_nxt;
      if (en) begin
        prescaler <= pre_nxt;
        idx       <= idx_nxt;
        digit_sel <= NUM_DIGITS'(1) << idx_nxt;
        seg       <= seg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cookie_serial_display.sv
// tb_cookie_serial_display: directed self-checking bench for
// cookie_serial_display with NUM_DIGITS=4, REFRESH_DIV=4, TIMEOUT_CYCLES=8.
module tb_cookie_serial_display;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int TC = 8;

  logic        clk = 1'b0;
  logic        rst, en, bit_in, bit_valid;
  logic [15:0] frame_word;
  logic        frame_done, frame_error;
  logic [4:0]  bit_count;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  cookie_serial_display #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RD),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .frame_word  (frame_word),
    .frame_done  (frame_done),
    .frame_error (frame_error),
    .bit_count   (bit_count),
    .seg         (seg),
    .digit_sel   (digit_sel)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_in    = w[15-i];
      tick();
    end
    bit_valid = 1'b0;
  endtask

  task automatic wait_digit(input logic [3:0] d);
    for (int i = 0; i < 40; i++) begin
      if (digit_sel === d) return;
      tick();
    end
    check("wait_digit", {28'b0, digit_sel}, {28'b0, d});
  endtask

  // Returns at the first negedge after digit 0 becomes active.
  task automatic sync_scan();
    logic [3:0] prev;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      prev = digit_sel;
      tick();
      if (digit_sel == 4'b0001 && prev != 4'b0001) ok = 1'b1;
    end
    check("sync_scan", {31'b0, ok}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w1, w2, w;
    int first, second, ndone, errs, dig;

    rst = 1'b1; en = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (3) tick();
    check("rst bit_count", bit_count, 0);
    check("rst frame_word", frame_word, 0);
    check("rst seg", seg, 7'h3F);
    check("rst digit_sel", digit_sel, 4'b0001);
    check("rst frame_done", frame_done, 0);
    check("rst frame_error", frame_error, 0);
    rst = 1'b0;

    // Basic frame
    send_bits(16'h1234, 16);
    check("f1 done", frame_done, 1);
    check("f1 word", frame_word, 16'h1234);
    check("f1 bit_count", bit_count, 0);
    tick();
    check("f1 done pulse", frame_done, 0);
    wait_digit(4'b0001);
    check("f1 seg d0", seg, 7'h66);
    wait_digit(4'b1000);
    check("f1 seg d3", seg, 7'h06);

    // Scan order and timing
    w = 16'hABCD;
    send_bits(w, 16);
    check("scan word", frame_word, w);
    sync_scan();
    for (int n = 0; n <= 16; n++) begin
      dig = (n / 4) % 4;
      check("scan sel", digit_sel, 4'b0001 << dig);
      check("scan seg", seg, glyph[w[4*dig +: 4]]);
      if (n < 16) tick();
    end

    // Back-to-back frames
    w1 = 16'h5A3C; w2 = 16'hF0E1;
    first = -1; second = -1; ndone = 0;
    for (int i = 0; i < 32; i++) begin
      bit_valid = 1'b1;
      bit_in = (i < 16) ? w1[15-i] : w2[31-i];
      tick();
      if (frame_done) begin
        ndone++;
        if (first < 0) first = i;
        else second = i;
        if (i == 15) check("b2b word1", frame_word, w1);
      end
    end
    bit_valid = 1'b0;
    check("b2b ndone", ndone, 2);
    check("b2b first", first, 15);
    check("b2b gap", second - first, 16);
    check("b2b word2", frame_word, w2);

    // Enable gating mid-frame
    w = 16'h9876;
    sync_scan();
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = w[15-i]; tick();
    end
    check("en bit_count pre", bit_count, 8);
    check("en sel pre", digit_sel, 4'b0100);
    en = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    repeat (10) tick();
    check("en bit_count hold", bit_count, 8);
    check("en sel hold", digit_sel, 4'b0100);
    check("en word hold", frame_word, w2);
    en = 1'b1;
    for (int i = 8; i < 16; i++) begin
      bit_valid = 1'b1; bit_in = w[15-i]; tick();
      if (i == 14) check("en sel k15", digit_sel, 4'b1000);
    end
    bit_valid = 1'b0;
    check("en sel k16", digit_sel, 4'b0001);
    check("en done", frame_done, 1);
    check("en word", frame_word, w);
    tick();
    check("en seg new", seg, 7'h7D);

    // Reset mid-frame
    send_bits(16'hFFFF, 7);
    check("mid bit_count", bit_count, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst bit_count", bit_count, 0);
    check("mrst word", frame_word, 0);
    check("mrst seg", seg, 7'h3F);
    check("mrst sel", digit_sel, 4'b0001);
    send_bits(16'h0C5E, 16);
    check("mrst recover", frame_word, 16'h0C5E);
    check("mrst done", frame_done, 1);

`ifdef COOKIE_DISP_TIMEOUT_EN
    send_bits(16'hB000, 5);
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 6) begin
        check("tmo cnt j6", bit_count, 5);
        check("tmo err j6", frame_error, 0);
      end
      if (j == 7) begin
        check("tmo err j7", frame_error, 1);
        check("tmo cnt j7", bit_count, 0);
        check("tmo word", frame_word, 16'h0C5E);
      end
      if (j == 8) check("tmo err pulse", frame_error, 0);
    end
    send_bits(16'hB000, 5);
    errs = 0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (frame_error) errs++;
    end
    bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    bit_valid = 1'b0;
    if (frame_error) errs++;
    check("tmo prevent err", errs, 0);
    check("tmo prevent cnt", bit_count, 6);
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (j == 6) check("tmo2 err j6", frame_error, 0);
      if (j == 7) check("tmo2 err j7", frame_error, 1);
    end
`else
    send_bits(16'hB000, 5);
    errs = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (frame_error) errs++;
    end
    check("hold errs", errs, 0);
    check("hold bit_count", bit_count, 5);
    check("hold word", frame_word, 16'h0C5E);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
